// File: rtl/taxi_qsfp_reset_ctrl.sv
// taxi_qsfp_reset_ctrl: QSFP28 ModPrsL debounce, shared ResetL pulse/init sequencing, per-cage ready, IntL status.
// Define QSFP_RESET_CTRL_INT_LATCH_EN for a sticky, clearable int_flag; otherwise int_flag is a READY-gated level.
module taxi_qsfp_reset_ctrl #(
    parameter int PORTS           = 2,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int RESET_CYCLES    = 1250,
    parameter int INIT_CYCLES     = 250000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] qsfp_modprs_l,
    input  logic             qsfp_int_l,
    input  logic             reset_req,
    input  logic             int_clr,
    output logic             qsfp_reset_l,
    output logic [PORTS-1:0] present,
    output logic [PORTS-1:0] mod_ready,
    output logic             busy,
    output logic             int_flag
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SEQ_MAX = RESET_CYCLES > INIT_CYCLES ? RESET_CYCLES : INIT_CYCLES;
    localparam int CW = $clog2(SEQ_MAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {ASSERT, INIT, READY} state_t;

    state_t                   state, state_next;
    logic [CW-1:0]            cnt, cnt_next;
    logic [PORTS-1:0]         modprs_s1, modprs_s2;
    logic                     int_s1, int_s2;
    logic [PORTS-1:0][DW-1:0] deb_cnt, deb_cnt_next;
    logic [PORTS-1:0]         present_next;
    logic                     ins_evt, restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modprs_s1 <= '1;
            modprs_s2 <= '1;
            int_s1    <= 1'b1;
            int_s2    <= 1'b1;
        end else begin
            modprs_s1 <= qsfp_modprs_l;
            modprs_s2 <= modprs_s1;
            int_s1    <= qsfp_int_l;
            int_s2    <= int_s1;
        end
    end

    // A port's counter runs only while the synced level disagrees with present
    always_comb begin
        present_next = present;
        deb_cnt_next = deb_cnt;
        for (int i = 0; i < PORTS; i++) begin
            if (modprs_s2[i] != present[i])
                deb_cnt_next[i] = '0;
            else if (deb_cnt[i] == DEB_LAST) begin
                deb_cnt_next[i] = '0;
                present_next[i] = ~modprs_s2[i];
            end else
                deb_cnt_next[i] = deb_cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present <= '0;
            deb_cnt <= '0;
        end else begin
            present <= present_next;
            deb_cnt <= deb_cnt_next;
        end
    end

    assign ins_evt = |(present_next & ~present);
    assign restart = (state != ASSERT) & (ins_evt | reset_req);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (restart) begin
            state_next = ASSERT;
            cnt_next   = '0;
        end else if (state == ASSERT) begin
            state_next = cnt == RST_LAST ? INIT : ASSERT;
            cnt_next   = cnt == RST_LAST ? '0 : cnt + 1'b1;
        end else if (state == INIT) begin
            state_next = cnt == INIT_LAST ? READY : INIT;
            cnt_next   = cnt == INIT_LAST ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ASSERT;
            cnt          <= '0;
            qsfp_reset_l <= 1'b0;
            mod_ready    <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            qsfp_reset_l <= state_next != ASSERT;
            mod_ready    <= {PORTS{state == READY}} & present;
        end
    end

    assign busy = state != READY;

`ifdef QSFP_RESET_CTRL_INT_LATCH_EN
    logic int_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_prev <= 1'b1;
            int_flag <= 1'b0;
        end else begin
            int_prev <= int_s2;
            int_flag <= (state != READY) ? 1'b0 : (int_prev & ~int_s2) ? 1'b1 : int_clr ? 1'b0 : int_flag;
        end
    end
`else
    logic unused_int_clr;

    assign unused_int_clr = int_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            int_flag <= 1'b0;
        else
            int_flag <= ~int_s2 & (state == READY);
    end
`endif

endmodule

// File: tb/tb_taxi_qsfp_reset_ctrl.sv
// tb_taxi_qsfp_reset_ctrl: directed sequences plus random stimulus against an elapsed-time reference model.
// Expectations follow QSFP_RESET_CTRL_INT_LATCH_EN the same way the design does.
module tb_taxi_qsfp_reset_ctrl;
    localparam int DC = 4;
    localparam int RC = 8;
    localparam int IC = 16;
`ifdef QSFP_RESET_CTRL_INT_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] qsfp_modprs_l = 2'b11;
    logic       qsfp_int_l = 1'b1;
    logic       reset_req = 1'b0;
    logic       int_clr = 1'b0;
    logic       qsfp_reset_l, busy, int_flag;
    logic [1:0] present, mod_ready;
    int         n_chk = 0;
    int         n_fail = 0;

    taxi_qsfp_reset_ctrl #(
        .PORTS(2), .DEBOUNCE_CYCLES(DC), .RESET_CYCLES(RC), .INIT_CYCLES(IC)
    ) dut (
        .clk(clk), .rst(rst), .qsfp_modprs_l(qsfp_modprs_l), .qsfp_int_l(qsfp_int_l),
        .reset_req(reset_req), .int_clr(int_clr), .qsfp_reset_l(qsfp_reset_l),
        .present(present), .mod_ready(mod_ready), .busy(busy), .int_flag(int_flag)
    );

    always #5 clk = ~clk;

    // Reference model: sequence phase is derived from cycles elapsed since the last ASSERT entry
    logic [1:0] m_s1, m_s2, m_pres, m_mr;
    logic       m_i1, m_i2, m_iprev, m_if;
    int         m_run [2];
    int         m_el;

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_pres = 2'b00; m_mr = 2'b00;
        m_i1 = 1'b1; m_i2 = 1'b1; m_iprev = 1'b1; m_if = 1'b0;
        m_run[0] = 0; m_run[1] = 0; m_el = 0;
    endtask

    task automatic model_step();
        logic [1:0] np;
        logic       rdy, in_assert, ins;
        rdy = m_el >= RC + IC;
        in_assert = m_el < RC;
        np = m_pres;
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] == m_pres[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    np[i] = ~m_pres[i];
                    m_run[i] = 0;
                end
            end else
                m_run[i] = 0;
        end
        ins = |(np & ~m_pres);
        m_mr = {2{rdy}} & m_pres;
        if (LATCH)
            m_if = !rdy ? 1'b0 : (m_iprev & ~m_i2) ? 1'b1 : int_clr ? 1'b0 : m_if;
        else
            m_if = ~m_i2 & rdy;
        m_iprev = m_i2;
        m_el = (!in_assert && (ins || reset_req)) ? 0 : (m_el < RC + IC ? m_el + 1 : m_el);
        m_pres = np;
        m_s2 = m_s1; m_s1 = qsfp_modprs_l;
        m_i2 = m_i1; m_i1 = qsfp_int_l;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        logic [6:0] exp;
        for (int j = 0; j < n; j++) begin
            if (rst) model_reset(); else model_step();
            @(negedge clk);
            exp = {m_el >= RC, m_el < RC + IC, m_pres, m_mr, m_if};
            chk("model {rl,busy,present,ready,int}", {qsfp_reset_l, busy, present, mod_ready, int_flag}, exp);
        end
    endtask

    typedef struct {
        int         k;
        logic       rl;
        logic       bz;
        logic [1:0] pr;
        logic [1:0] mr;
    } vec_t;

    vec_t tbl [6];
    int   k;

    initial begin
        tbl[0] = '{0, 1'b0, 1'b1, 2'b00, 2'b00};
        tbl[1] = '{7, 1'b0, 1'b1, 2'b00, 2'b00};
        tbl[2] = '{8, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[3] = '{23, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[4] = '{24, 1'b1, 1'b0, 2'b00, 2'b00};
        tbl[5] = '{30, 1'b1, 1'b0, 2'b00, 2'b00};
        model_reset();
        step(5);
        chk("reset state", {qsfp_reset_l, busy, present, mod_ready, int_flag}, 7'b0_1_00_00_0);
        rst = 1'b0;
        k = 0;
        foreach (tbl[i]) begin
            while (k < tbl[i].k) begin
                step();
                k++;
            end
            chk($sformatf("power-up k=%0d", tbl[i].k), {qsfp_reset_l, busy, present, mod_ready},
                {tbl[i].rl, tbl[i].bz, tbl[i].pr, tbl[i].mr});
        end

        for (int g = 0; g < 2; g++) begin
            qsfp_modprs_l[0] = 1'b0; step(2);
            qsfp_modprs_l[0] = 1'b1; step(2);
        end
        step(3);
        chk("glitch present", present, 2'b00);
        chk("glitch reset_l", qsfp_reset_l, 1'b1);
        qsfp_modprs_l[0] = 1'b0;
        step(5); chk("ins before debounce", present, 2'b00);
        step();  chk("ins present", present, 2'b01);
        chk("ins reset_l low", qsfp_reset_l, 1'b0);
        step(7); chk("ins pulse end", qsfp_reset_l, 1'b0);
        step();  chk("ins pulse release", {qsfp_reset_l, busy}, 2'b11);
        step(15); chk("ins init busy", busy, 1'b1);
        step();  chk("ins ready", {busy, mod_ready}, 3'b0_00);
        step();  chk("ins mod_ready", mod_ready, 2'b01);

        qsfp_modprs_l[1] = 1'b0;
        step(32); chk("both ready", mod_ready, 2'b11);
        qsfp_modprs_l[1] = 1'b1;
        step(5); chk("rem before debounce", present, 2'b11);
        step();  chk("rem present", {qsfp_reset_l, present, mod_ready}, 5'b1_01_11);
        step();  chk("rem mod_ready", {qsfp_reset_l, busy, mod_ready}, 4'b1_0_01);
        step(10); chk("rem no pulse", {qsfp_reset_l, mod_ready}, 3'b1_01);

        reset_req = 1'b1; step(); reset_req = 1'b0;
        chk("req from ready", {qsfp_reset_l, busy}, 2'b01);
        step(3);
        reset_req = 1'b1; step(); reset_req = 1'b0;
        step(3); chk("req in assert no restart", qsfp_reset_l, 1'b0);
        step();  chk("req in assert no extension", qsfp_reset_l, 1'b1);
        step(10);
        reset_req = 1'b1; step(); reset_req = 1'b0;
        chk("req at init 10", {qsfp_reset_l, busy}, 2'b01);
        step(7); chk("req init pulse end", qsfp_reset_l, 1'b0);
        step();  chk("req init release", qsfp_reset_l, 1'b1);
        step(15);
        reset_req = 1'b1; step(); reset_req = 1'b0;
        chk("req at final init count", {qsfp_reset_l, busy}, 2'b01);
        step(24); chk("req seq done", {qsfp_reset_l, busy}, 2'b10);
        step();  chk("req mod_ready", mod_ready, 2'b01);

        qsfp_int_l = 1'b0; step(); qsfp_int_l = 1'b1;
        step(2); chk("int set", int_flag, 1'b1);
        step();  chk("int after pulse", int_flag, LATCH);
        step(3); chk("int held", int_flag, LATCH);
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("int clr", int_flag, 1'b0);
        qsfp_int_l = 1'b0; step(); qsfp_int_l = 1'b1;
        step();
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("int clr with edge", int_flag, 1'b1);
        step();  chk("int clr with edge hold", int_flag, LATCH);
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("int clr again", int_flag, 1'b0);
        reset_req = 1'b1; step(); reset_req = 1'b0;
        step(10);
        qsfp_int_l = 1'b0; step(5);
        chk("int in init", int_flag, 1'b0);
        qsfp_int_l = 1'b1; step(13);
        chk("int after init", {busy, int_flag}, 2'b00);

        reset_req = 1'b1; step(); reset_req = 1'b0;
        step(12);
        rst = 1'b1;
        #1;
        chk("async rst", {qsfp_reset_l, busy, present, mod_ready, int_flag}, 7'b0_1_00_00_0);
        step(2);
        rst = 1'b0;
        step(7); chk("rerun pulse", qsfp_reset_l, 1'b0);
        step();  chk("rerun release", qsfp_reset_l, 1'b1);
        step(16); chk("rerun ready", busy, 1'b0);
        step();  chk("rerun mod_ready", mod_ready, 2'b01);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 23) == 0) begin
                int p;
                p = int'($urandom_range(0, 1));
                qsfp_modprs_l[p] = ~qsfp_modprs_l[p];
            end
            if ($urandom_range(0, 7) == 0) qsfp_int_l = ~qsfp_int_l;
            reset_req = $urandom_range(0, 99) == 0;
            int_clr = $urandom_range(0, 9) == 0;
            rst = $urandom_range(0, 1499) == 0;
            step();
        end
        rst = 1'b0; reset_req = 1'b0; int_clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
